// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operand handshake towards the unit,
// registered result pulse back to the consumer.
interface seq_alu_if #(
    parameter int WIDTH = 8
) ();
    logic               valid_i;
    logic               ready_o;
    logic [WIDTH-1:0]   a_i;
    logic [WIDTH-1:0]   b_i;
    logic               en_a_i;
    logic               en_b_i;
    logic [2:0]         sel_i;
    logic               clr_acc_i;
    logic [2*WIDTH-1:0] result_o;
    logic               valid_o;
    logic               err_o;

    modport master (
        output valid_i, a_i, b_i, en_a_i, en_b_i, sel_i, clr_acc_i,
        input  ready_o, result_o, valid_o, err_o
    );

    modport slave (
        input  valid_i, a_i, b_i, en_a_i, en_b_i, sel_i, clr_acc_i,
        output ready_o, result_o, valid_o, err_o
    );
endinterface

// File: rtl/seq_alu.sv
// Handshaked arithmetic unit: single-cycle add/sub, iterative shift-add
// multiply (signed, unsigned, multiply-accumulate) with an error flag.
module seq_alu #(
    parameter int         WIDTH     = 8,
    parameter logic [2:0] ADD_MODE  = 3'b000,
    parameter logic [2:0] SUB_MODE  = 3'b001,
    parameter logic [2:0] MUL_MODE  = 3'b010,
    parameter logic [2:0] MULU_MODE = 3'b011,
    parameter logic [2:0] MAC_MODE  = 3'b100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    seq_alu_if.slave    bus
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [CW-1:0] DONE_CNT  = CW'(WIDTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, cap_a, cap_b;
    logic [2:0]       op_sel;
    logic             alu_pend;
    logic [RW-1:0]    mcand, prod, acc;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             accept, sel_is_mul, mul_done, alu_err;
    logic [RW-1:0]    alu_res, pp_term, prod_step, acc_base, mac_sum;

    always_comb begin
        state_nxt   = state;
        bus.ready_o = (state == IDLE) && !rst_i;
        accept      = bus.valid_i && bus.ready_o;
        sel_is_mul  = bus.sel_i inside {MUL_MODE, MULU_MODE, MAC_MODE};
        mul_done    = (state == BUSY) && (cnt == DONE_CNT);
        cap_a       = bus.en_a_i ? bus.a_i : '0;
        cap_b       = bus.en_b_i ? bus.b_i : '0;
        case (state)
            IDLE:    if (accept && sel_is_mul) state_nxt = BUSY;
            BUSY:    if (mul_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle ops work on operands registered at the accept edge.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_sel)
            ADD_MODE: alu_res = {{WIDTH{op_a[WIDTH-1]}}, op_a} + {{WIDTH{op_b[WIDTH-1]}}, op_b};
            SUB_MODE: alu_res = {{WIDTH{op_a[WIDTH-1]}}, op_a} - {{WIDTH{op_b[WIDTH-1]}}, op_b};
            default:  alu_err = 1'b1;
        endcase
    end

    // For signed multipliers the top bit weighs -2^(W-1), so its partial
    // product is subtracted; this keeps -2^(W-1) * -2^(W-1) exact.
    always_comb begin
        pp_term   = mplier[0] ? mcand : '0;
        prod_step = ((cnt == LAST_ITER) && (op_sel != MULU_MODE)) ? (prod - pp_term)
                                                                  : (prod + pp_term);
        acc_base  = bus.clr_acc_i ? '0 : acc;
        mac_sum   = acc_base + prod;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            op_a         <= '0;
            op_b         <= '0;
            op_sel       <= '0;
            alu_pend     <= 1'b0;
            mcand        <= '0;
            mplier       <= '0;
            prod         <= '0;
            cnt          <= '0;
            acc          <= '0;
            bus.result_o <= '0;
            bus.valid_o  <= 1'b0;
            bus.err_o    <= 1'b0;
        end else begin
            state       <= state_nxt;
            bus.valid_o <= 1'b0;
            bus.err_o   <= 1'b0;
            alu_pend    <= 1'b0;

            if (accept) begin
                op_a     <= cap_a;
                op_b     <= cap_b;
                op_sel   <= bus.sel_i;
                alu_pend <= !sel_is_mul;
                mcand    <= (bus.sel_i == MULU_MODE) ? {{WIDTH{1'b0}}, cap_a}
                                                     : {{WIDTH{cap_a[WIDTH-1]}}, cap_a};
                mplier   <= cap_b;
                prod     <= '0;
                cnt      <= '0;
            end

            if (alu_pend) begin
                bus.result_o <= alu_res;
                bus.valid_o  <= 1'b1;
                bus.err_o    <= alu_err;
            end

            if (state == BUSY) begin
                if (!mul_done) begin
                    prod   <= prod_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end else begin
                    bus.result_o <= (op_sel == MAC_MODE) ? mac_sum : prod;
                    bus.valid_o  <= 1'b1;
                end
            end

            if (mul_done && (op_sel == MAC_MODE)) begin
                acc <= mac_sum;
            end else if (bus.clr_acc_i) begin
                acc <= '0;
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed scenarios plus random operations
// checked against an arithmetic reference model.
module tb_seq_alu;
    localparam int W  = 8;
    localparam int RW = 2 * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [RW-1:0] acc_model = '0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the captured operands.
    task automatic modelOp(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit ena, input bit enb, input bit clr,
                           output logic [RW-1:0] res, output bit err, output int lat);
        longint sa, sb, ua, ub;
        logic [W-1:0] ma, mb;
        ma  = ena ? a : '0;
        mb  = enb ? b : '0;
        sa  = longint'($signed(ma));
        sb  = longint'($signed(mb));
        ua  = longint'(ma);
        ub  = longint'(mb);
        err = 1'b0;
        res = '0;
        lat = (sel inside {3'd2, 3'd3, 3'd4}) ? W + 1 : 1;
        if (clr) acc_model = '0;
        case (sel)
            3'd0: res = RW'(sa + sb);
            3'd1: res = RW'(sa - sb);
            3'd2: res = RW'(sa * sb);
            3'd3: res = RW'(ua * ub);
            3'd4: begin
                acc_model = RW'(longint'(acc_model) + sa * sb);
                res       = acc_model;
            end
            default: err = 1'b1;
        endcase
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] sel, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit ena, input bit enb,
                                 input bit clr, input bit hold);
        logic [RW-1:0] exp_res;
        bit exp_err;
        int lat, n;
        modelOp(sel, a, b, ena, enb, clr, exp_res, exp_err, lat);
        @(negedge clk);
        bus.valid_i = 1'b1; bus.sel_i = sel; bus.a_i = a; bus.b_i = b;
        bus.en_a_i = ena; bus.en_b_i = enb;
        checkOutput({tag, ".ready"}, 64'(bus.ready_o), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.valid_i   = hold;
        bus.sel_i     = 3'd0;
        bus.a_i       = 8'h01;
        bus.clr_acc_i = clr && (lat == 1);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            bus.clr_acc_i = clr && (n == lat - 1);
            if (bus.valid_o) break;
            if (n < lat) checkOutput({tag, ".busy"}, 64'(bus.ready_o), 64'd0);
        end
        bus.valid_i   = 1'b0;
        bus.clr_acc_i = 1'b0;
        checkOutput({tag, ".latency"}, 64'(n), 64'(lat));
        checkOutput({tag, ".result"}, 64'(bus.result_o), 64'(exp_res));
        checkOutput({tag, ".err"}, 64'(bus.err_o), 64'(exp_err));
        checkOutput({tag, ".ready_done"}, 64'(bus.ready_o), 64'd1);
        @(negedge clk);
        checkOutput({tag, ".pulse"}, 64'({bus.valid_o, bus.err_o}), 64'd0);
    endtask

    task automatic clearAcc();
        @(negedge clk);
        bus.clr_acc_i = 1'b1;
        acc_model     = '0;
        @(negedge clk);
        bus.clr_acc_i = 1'b0;
        checkOutput("clr.novalid", 64'(bus.valid_o), 64'd0);
    endtask

    initial begin
        bit saw;
        bus.valid_i = 1'b0; bus.a_i = '0; bus.b_i = '0;
        bus.en_a_i = 1'b1; bus.en_b_i = 1'b1; bus.sel_i = '0; bus.clr_acc_i = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset.ready", 64'(bus.ready_o), 64'd0);
        checkOutput("reset.outs", 64'({bus.valid_o, bus.err_o, bus.result_o}), 64'd0);
        rst = 1'b0;

        // Back-to-back ADD then SUB at throughput 1.
        @(negedge clk);
        bus.valid_i = 1'b1; bus.sel_i = 3'd0; bus.a_i = 8'h7F; bus.b_i = 8'h01;
        @(posedge clk);
        @(negedge clk);
        bus.sel_i = 3'd1; bus.a_i = 8'h80; bus.b_i = 8'h01;
        checkOutput("b2b.ready", 64'(bus.ready_o), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        checkOutput("b2b.add", 64'({bus.valid_o, bus.err_o, bus.result_o}), {47'd0, 1'b1, 1'b0, 16'h0080});
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b.sub", 64'({bus.valid_o, bus.err_o, bus.result_o}), {47'd0, 1'b1, 1'b0, 16'hFF7F});

        applyStimulus("mul_neg", 3'd2, 8'hFD, 8'h05, 1, 1, 0, 1);
        checkOutput("mul_neg.const", 64'(bus.result_o), 64'hFFF1);
        applyStimulus("mul_min", 3'd2, 8'h80, 8'h80, 1, 1, 0, 0);
        checkOutput("mul_min.const", 64'(bus.result_o), 64'h4000);
        applyStimulus("mulu_ff", 3'd3, 8'hFF, 8'hFF, 1, 1, 0, 0);
        checkOutput("mulu_ff.const", 64'(bus.result_o), 64'hFE01);
        applyStimulus("mulu_enb", 3'd3, 8'h12, 8'h34, 1, 0, 0, 0);

        clearAcc();
        applyStimulus("mac1", 3'd4, 8'h03, 8'h04, 1, 1, 0, 0);
        checkOutput("mac1.const", 64'(bus.result_o), 64'h000C);
        applyStimulus("mac2", 3'd4, 8'hFE, 8'h05, 1, 1, 0, 0);
        checkOutput("mac2.const", 64'(bus.result_o), 64'h0002);
        applyStimulus("mac_clr", 3'd4, 8'h02, 8'h02, 1, 1, 1, 0);
        checkOutput("mac_clr.const", 64'(bus.result_o), 64'h0004);

        applyStimulus("badop", 3'd7, 8'h55, 8'h66, 1, 1, 0, 0);
        applyStimulus("add_after_err", 3'd0, 8'h10, 8'h20, 1, 1, 0, 0);

        // Reset three cycles into a multiply discards it and clears the accumulator.
        applyStimulus("mac_pre_rst", 3'd4, 8'h01, 8'h05, 1, 1, 0, 0);
        @(negedge clk);
        bus.valid_i = 1'b1; bus.sel_i = 3'd2; bus.a_i = 8'h12; bus.b_i = 8'h34;
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        acc_model = '0;
        @(negedge clk);
        checkOutput("rst_mid.outs", 64'({bus.ready_o, bus.valid_o, bus.err_o, bus.result_o}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid.ready", 64'(bus.ready_o), 64'd1);
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.valid_o) saw = 1'b1;
        end
        checkOutput("rst_mid.novalid", 64'(saw), 64'd0);
        applyStimulus("rst_mac", 3'd4, 8'h01, 8'h01, 1, 1, 0, 0);
        applyStimulus("rst_add", 3'd0, 8'h01, 8'h01, 1, 1, 0, 0);
        checkOutput("rst_add.const", 64'(bus.result_o), 64'h0002);

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] sel;
            bit is_mul;
            sel    = 3'($urandom_range(0, 7));
            is_mul = sel inside {3'd2, 3'd3, 3'd4};
            if ($urandom_range(0, 7) == 0) clearAcc();
            applyStimulus("rand", sel, 8'($urandom), 8'($urandom),
                          $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                          is_mul && ($urandom_range(0, 3) == 0),
                          is_mul && ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked arithmetic unit; successor to the fixed 8-bit add/sub/mul block with registered operands. Adds a generic operand width, a valid/ready input handshake, and a multi-cycle shift-add multiplier in place of a single-cycle multiply. Also adds unsigned multiply, a multiply-accumulate mode and an error flag. Sits between operand-producing datapath logic and the result consumer.

Parameters:
WIDTH, 8, operand width in bits (>=2); result width is 2*WIDTH.
ADD_MODE, 3'b000, opcode: signed add.
SUB_MODE, 3'b001, opcode: signed subtract (a-b).
MUL_MODE, 3'b010, opcode: signed multiply.
MULU_MODE, 3'b011, opcode: unsigned multiply.
MAC_MODE, 3'b100, opcode: signed multiply-accumulate.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
valid_i  in  1  operation request.
ready_o  out  1  unit can accept a request this cycle.
a_i  in  WIDTH  operand A.
b_i  in  WIDTH  operand B.
en_a_i  in  1  0: operand A captured as 0.
en_b_i  in  1  0: operand B captured as 0.
sel_i  in  3  opcode.
clr_acc_i  in  1  synchronous accumulator clear.
result_o  out  2*WIDTH  result, held until next result.
valid_o  out  1  one-cycle pulse: result_o updated this cycle.
err_o  out  1  qualifies valid_o: unsupported opcode.

Behaviour:
- Reset (async assert, sync release): state IDLE, result_o=0, valid_o=0, err_o=0, accumulator=0, ready_o=0 while rst_i is high.
- FSM states: IDLE and BUSY. ready_o=1 in IDLE only.
- Accept: valid_i&&ready_o at a rising edge. At that edge, latch opA=(en_a_i?a_i:0), opB=(en_b_i?b_i:0) and sel_i. valid_i while ready_o=0 is ignored and not queued.
- ADD/SUB: operands sign-extended to 2*WIDTH before the operation; wraps mod 2^(2*WIDTH). result_o and valid_o update at the edge after accept (latency 1). State stays IDLE, so back-to-back ops reach throughput 1.
- Unsupported opcode: latency 1, result_o=0, valid_o=1 with err_o=1. err_o is 0 on every other valid_o pulse and 0 whenever valid_o=0.
- MUL/MULU/MAC: go to BUSY at accept. Iterative radix-2 shift-add, one partial product per cycle, WIDTH iterations.
  - Signed modes: the 2*WIDTH-bit two's-complement product; -2^(W-1) * -2^(W-1) must be exact.
  - MULU: unsigned product.
  - valid_o pulses WIDTH+1 edges after the accept edge. FSM returns to IDLE on that edge, so ready_o=1 in the valid_o cycle.
- MAC: acc_next = acc + signed product, mod 2^(2*WIDTH). result_o=acc_next, and acc is updated on the same edge as valid_o.
- clr_acc_i: sets acc to 0 at the next edge, in any state.
  - If clr_acc_i and a MAC completion share an edge, acc = product (the clear takes effect before the add).
  - A clear never generates valid_o.
- Operand or sel_i changes during BUSY have no effect.
- Reset mid-operation: the operation is discarded, no valid_o, acc=0.

Test Plan:
1. WIDTH=8. ADD, a=0x7F, b=0x01 -> result_o=0x0080, valid_o 1 cycle after accept. Then back-to-back SUB a=0x80, b=0x01 on the next cycle -> 0xFF7F on the following cycle.
2. MUL, a=0xFD (-3), b=0x05 -> ready_o low 8 cycles, result_o=0xFFF1 at edge 9. valid_i held high during BUSY with a=0x01 -> no extra result. MUL 0x80*0x80 -> 0x4000.
3. MULU, 0xFF*0xFF -> 0xFE01. en_b_i=0, a=0x12, b=0x34 -> 0x0000 after 9 cycles.
4. MAC sequence:
   - clr_acc_i, then MAC 3*4 -> 0x000C.
   - MAC 0xFE (-2)*5 -> 0x0002.
   - clr_acc_i asserted on the completion edge of MAC 2*2 -> 0x0004.
5. sel_i=3'b111 -> valid_o=1, err_o=1, result_o=0x0000 after 1 cycle. A following ADD pulse has err_o=0.
6. Assert rst_i 3 cycles into a MUL -> valid_o stays 0, result_o=0, acc=0, ready_o=1 the cycle after release. A new ADD 1+1 -> 0x0002.
